// File: rtl/vga_timing_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, derived totals and
// active-window starts, capture FSM state type and small counter helpers.
package vga_timing_pkg;

  // Default horizontal timing, in pixel clocks
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  // Default vertical timing, in lines
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  // Derived totals (800 clocks per line, 525 lines per frame)
  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // First active pixel / line relative to the counters. The vertical start is
  // one lower because vsync falls mid-line, ahead of the hsync fall that
  // clears the line counter.
  localparam int H_ACT_START_DEF = H_SYNC_DEF + H_BP_DEF;
  localparam int V_ACT_START_DEF = V_SYNC_DEF + V_BP_DEF - 1;

  // Counter widths and saturation limits
  localparam int             CNT_W       = 10;
  localparam int             ADDR_W      = 19;
  localparam logic [9:0]     CNT_MAX     = 10'd1023;
  localparam logic [7:0]     ERR_CNT_MAX = 8'd255;

  // Lock acquisition states
  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } cap_state_e;

  // Saturating increment for the 10-bit position counters
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // Saturating increment for the 8-bit error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

  // Half-open range test lo <= v < hi
  function automatic logic in_range10(input logic [9:0] v,
                                      input logic [9:0] lo,
                                      input logic [9:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_capture.sv
// VGA capture: registers the incoming 12-bit RGB video with its sync pair,
// rebuilds pixel/line position from the sync edges, verifies line and frame
// lengths, acquires lock over two clean frame boundaries and, once locked,
// emits a write strobe with pixel data, coordinates and a linear address.
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic              i_clk25m,
  input  logic              i_rstn_clk25m,
  input  logic [3:0]        i_vga_red,
  input  logic [3:0]        i_vga_green,
  input  logic [3:0]        i_vga_blue,
  input  logic              i_vga_hsync,
  input  logic              i_vga_vsync,
  output logic              o_pix_valid,
  output logic [11:0]       o_pix_data,
  output logic [9:0]        o_pix_x,
  output logic [9:0]        o_pix_y,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic              o_frame_start,
  output logic              o_locked,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
);

  // Timing derived from the parameters
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_VISIBLE);
  localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP - 1 + V_VISIBLE);

  // Input stage S1 and the previous S1 sync levels for edge detection
  logic        hs_s1_q, hs_s1_d;
  logic        vs_s1_q, vs_s1_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [3:0]  red_s1_q, red_s1_d;
  logic [3:0]  grn_s1_q, grn_s1_d;
  logic [3:0]  blu_s1_q, blu_s1_d;

  // Position tracking and lock state
  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        pend_q, pend_d;
  cap_state_e  state_q, state_d;

  // Registered outputs
  logic              valid_q, valid_d;
  logic [11:0]       data_q, data_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fstart_q, fstart_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  // Combinational event and window terms
  logic        hs_fall_s;
  logic        vs_fall_s;
  logic        boundary_s;
  logic        line_err_s;
  logic        frame_err_s;
  logic        sync_loss_s;
  logic        err_evt_s;
  logic        in_win_s;
  logic        first_pix_s;
  logic [9:0]  px_s;
  logic [9:0]  py_s;

  // Next-state logic for the input stage, counters, FSM and outputs
  always_comb begin
    // input stage simply follows the pins
    hs_s1_d   = i_vga_hsync;
    vs_s1_d   = i_vga_vsync;
    red_s1_d  = i_vga_red;
    grn_s1_d  = i_vga_green;
    blu_s1_d  = i_vga_blue;
    hs_prev_d = hs_s1_q;
    vs_prev_d = vs_s1_q;

    // sync edges are taken between S1 and its previous value
    hs_fall_s  = ~hs_s1_q & hs_prev_q;
    vs_fall_s  = ~vs_s1_q & vs_prev_q;
    // only a vsync fall seen on an earlier cycle qualifies this hsync fall,
    // so a coincident vsync fall waits for the next line
    boundary_s = hs_fall_s & pend_q;

    // horizontal counter: cleared on hsync fall, otherwise saturating count
    if (hs_fall_s) begin
      hcnt_d = 10'd0;
    end else begin
      hcnt_d = sat_inc10(hcnt_q);
    end

    // vertical counter advances only on line starts
    if (boundary_s) begin
      vcnt_d = 10'd0;
    end else if (hs_fall_s) begin
      vcnt_d = sat_inc10(vcnt_q);
    end else begin
      vcnt_d = vcnt_q;
    end

    // pending frame flag: set wins over the clear of a coincident boundary
    if (vs_fall_s) begin
      pend_d = 1'b1;
    end else if (boundary_s) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end

    // timing checks use the counters before they are cleared
    line_err_s  = hs_fall_s & (hcnt_q != H_LAST);
    frame_err_s = boundary_s & (vcnt_q != V_LAST);
    sync_loss_s = ~hs_fall_s & (hcnt_q == (CNT_MAX - 10'd1));
    err_evt_s   = (state_q != ST_SEARCH) & (line_err_s | frame_err_s | sync_loss_s);

    // lock acquisition
    case (state_q)
      ST_SEARCH: begin
        if (boundary_s) begin
          state_d = ST_VERIFY;
        end else begin
          state_d = ST_SEARCH;
        end
      end
      ST_VERIFY: begin
        if (err_evt_s) begin
          state_d = ST_SEARCH;
        end else if (boundary_s) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (err_evt_s) begin
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    // the S1 pixel sits at position (hcnt_d, vcnt_d)
    in_win_s    = in_range10(hcnt_d, H_ACT_LO, H_ACT_HI) &
                  in_range10(vcnt_d, V_ACT_LO, V_ACT_HI);
    px_s        = hcnt_d - H_ACT_LO;
    py_s        = vcnt_d - V_ACT_LO;
    first_pix_s = (px_s == 10'd0) & (py_s == 10'd0);

    // using state_d stops the strobe on the very pixel an error is seen
    valid_d  = (state_d == ST_LOCKED) & in_win_s;
    fstart_d = valid_d & first_pix_s;
    locked_d = (state_d == ST_LOCKED);

    // pixel payload and address update only with a valid pixel
    if (valid_d) begin
      data_d = {red_s1_q, grn_s1_q, blu_s1_q};
      x_d    = px_s;
      y_d    = py_s;
      if (first_pix_s) begin
        addr_d = {ADDR_W{1'b0}};
      end else begin
        addr_d = addr_q + 19'd1;
      end
    end else begin
      data_d = data_q;
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
    end

    // error pulse and saturating error count
    err_d = err_evt_s;
    if (err_evt_s) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) begin
      hs_s1_q   <= 1'b1;
      vs_s1_q   <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      red_s1_q  <= 4'd0;
      grn_s1_q  <= 4'd0;
      blu_s1_q  <= 4'd0;
      hcnt_q    <= 10'd0;
      vcnt_q    <= 10'd0;
      pend_q    <= 1'b0;
      state_q   <= ST_SEARCH;
      valid_q   <= 1'b0;
      data_q    <= 12'd0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      addr_q    <= {ADDR_W{1'b0}};
      fstart_q  <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      hs_s1_q   <= hs_s1_d;
      vs_s1_q   <= vs_s1_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      red_s1_q  <= red_s1_d;
      grn_s1_q  <= grn_s1_d;
      blu_s1_q  <= blu_s1_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      fstart_q  <= fstart_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_pix_valid   = valid_q;
  assign o_pix_data    = data_q;
  assign o_pix_x       = x_q;
  assign o_pix_y       = y_q;
  assign o_pix_addr    = addr_q;
  assign o_frame_start = fstart_q;
  assign o_locked      = locked_q;
  assign o_err         = err_q;
  assign o_err_cnt     = err_cnt_q;

endmodule
